// File: rtl/l2_mem_arbiter_pkg.sv
// Shared LC-3b memory-side types used by the L2 memory arbiter.
package lc3b_types;

  localparam int WORD_BITS = 16;
  localparam int LINE_BITS = 128;

  typedef logic [LINE_BITS-1:0] lc3b_line;
  typedef logic [WORD_BITS-1:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_RD   = 2'd2,
    D_WR   = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_side_t;

endpackage

// File: rtl/l2_mem_arbiter.sv
// Arbitrates split I/D line requests onto one physical-memory port.
// Optional round-robin tie-break: define ARB_ROUND_ROBIN_EN (default: D side wins ties).
//
// state  | meaning
// IDLE   | no transaction; grants a pending request at the next edge
// I_BUSY | pmem read on behalf of the I side
// D_RD   | pmem read on behalf of the D side
// D_WR   | pmem write on behalf of the D side
module l2_mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = WORD_BITS,
  parameter int LINE_W = LINE_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic              i_mem_resp,
  output logic [LINE_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic              d_mem_resp,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              i_req, d_req, pick_d;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

`ifdef ARB_ROUND_ROBIN_EN
  arb_side_t last_grant_q, last_grant_d;

  assign pick_d = d_req && (!i_req || (last_grant_q == ARB_I));

  always_ff @(posedge clk) begin
    if (!reset_n) last_grant_q <= ARB_I;
    else          last_grant_q <= last_grant_d;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && (i_req || d_req)) begin
      last_grant_d = pick_d ? ARB_D : ARB_I;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Address/data latch only on a grant so busy states ignore requester changes.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          addr_d = d_mem_address;
          if (d_mem_write) begin
            state_d = D_WR;
            wdata_d = d_mem_wdata;
          end else begin
            state_d = D_RD;
          end
        end else if (i_req) begin
          addr_d  = i_mem_address;
          state_d = I_BUSY;
        end
      end
      I_BUSY, D_RD, D_WR: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ownership comes from the state, not the live request lines.
  always_comb begin
    pmem_read    = (state_q == I_BUSY) || (state_q == D_RD);
    pmem_write   = (state_q == D_WR);
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_mem_resp   = (state_q == I_BUSY) && pmem_resp;
    d_mem_resp   = ((state_q == D_RD) || (state_q == D_WR)) && pmem_resp;
    i_mem_rdata  = i_mem_resp ? pmem_rdata : '0;
    d_mem_rdata  = d_mem_resp ? pmem_rdata : '0;
  end

endmodule
